// File: rtl/tracker_display_scheduler.sv
// Display scheduler for the step tracker's shared four-digit BCD display.
// Rotates round-robin among requesting page sources with a fixed dwell per page;
// a rising milestone alert pre-empts the rotation and pins the step-count page.
module tracker_display_scheduler #(
    parameter int unsigned DWELL       = 16,
    parameter int unsigned ALERT_DWELL = 32
) (
    input  logic        step_clk,
    input  logic        reset,
    input  logic [3:0]  page_req,
    input  logic        alert,
    input  logic        freeze,
    input  logic [19:0] page0_bcd,
    input  logic [19:0] page1_bcd,
    input  logic [19:0] page2_bcd,
    input  logic [19:0] page3_bcd,
    output logic [4:0]  bcd3,
    output logic [4:0]  bcd2,
    output logic [4:0]  bcd1,
    output logic [4:0]  bcd0,
    output logic [1:0]  page,
    output logic        alert_active,
    output logic        page_change
);

    localparam int unsigned DW = $clog2(DWELL);
    localparam int unsigned AW = $clog2(ALERT_DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [AW-1:0] ALERT_LAST = AW'(ALERT_DWELL - 1);
    localparam logic [19:0]   BLANK      = {4{5'h1F}};

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StAlert
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    page_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [AW-1:0] alert_cnt_q, alert_cnt_d;
    logic          alert_q;
    logic          alert_rise;
    logic          use_adv;
    logic [1:0]    adv_from;
    logic [2:0]    adv;
    logic [19:0]   disp;

    // Cyclic search from+1, from+2, from+3, from; returns {found, index}.
    function automatic logic [2:0] next_req(input logic [3:0] req, input logic [1:0] from);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = from + k[1:0];
            if (!res[2] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign alert_rise = alert & ~alert_q;

    // Next-state: alert edge first, then per-state dwell/rotation rules.
    always_comb begin
        state_d     = state_q;
        page_d      = page;
        dwell_cnt_d = dwell_cnt_q;
        alert_cnt_d = alert_cnt_q;
        use_adv     = 1'b0;
        adv_from    = page;
        if (alert_rise) begin
            state_d     = StAlert;
            page_d      = 2'd0;
            alert_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Searching from page 3 yields the lowest requested index.
                    if (|page_req) begin
                        use_adv  = 1'b1;
                        adv_from = 2'd3;
                    end
                end
                StShow: begin
                    if (!page_req[page] || (!freeze && dwell_cnt_q == DWELL_LAST)) begin
                        use_adv = 1'b1;
                    end else if (!freeze) begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end
                end
                StAlert: begin
                    if (alert_cnt_q == ALERT_LAST) begin
                        if (page_req[0]) begin
                            state_d     = StShow;
                            page_d      = 2'd0;
                            dwell_cnt_d = '0;
                        end else begin
                            use_adv  = 1'b1;
                            adv_from = 2'd0;
                        end
                    end else begin
                        alert_cnt_d = alert_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        adv = next_req(page_req, adv_from);
        if (use_adv) begin
            if (adv[2]) begin
                state_d     = StShow;
                page_d      = adv[1:0];
                dwell_cnt_d = '0;
            end else begin
                state_d = StIdle;
            end
        end
    end

    // State and registered outputs; page_change flags any visible display change.
    always_ff @(posedge step_clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            page         <= 2'd0;
            dwell_cnt_q  <= '0;
            alert_cnt_q  <= '0;
            alert_q      <= 1'b0;
            alert_active <= 1'b0;
            page_change  <= 1'b0;
        end else begin
            state_q      <= state_d;
            page         <= page_d;
            dwell_cnt_q  <= dwell_cnt_d;
            alert_cnt_q  <= alert_cnt_d;
            alert_q      <= alert;
            alert_active <= (state_d == StAlert);
            page_change  <= (page_d != page) ||
                            ((state_d == StAlert) != alert_active) ||
                            ((state_d == StIdle) != (state_q == StIdle));
        end
    end

    // Digit mux; reset blanks the display without waiting for a clock.
    always_comb begin
        disp = BLANK;
        if (!reset) begin
            unique case (state_q)
                StShow: begin
                    unique case (page)
                        2'd0: disp = page0_bcd;
                        2'd1: disp = page1_bcd;
                        2'd2: disp = page2_bcd;
                        2'd3: disp = page3_bcd;
                        default: disp = BLANK;
                    endcase
                end
                StAlert: disp = page0_bcd;
                default: disp = BLANK;
            endcase
        end
    end

    assign {bcd3, bcd2, bcd1, bcd0} = disp;

endmodule

// File: tb/tb_tracker_display_scheduler.sv
// Directed bench for tracker_display_scheduler with DWELL=4, ALERT_DWELL=3.
module tb_tracker_display_scheduler;

    localparam logic [19:0] BLANK = 20'hFFFFF;
    localparam logic [19:0] P0    = {5'd1, 5'd2, 5'd3, 5'd4};
    localparam logic [19:0] P0B   = {5'd9, 5'd8, 5'd7, 5'd6};
    localparam logic [19:0] P1    = {5'd5, 5'd6, 5'd7, 5'd8};
    localparam logic [19:0] P2    = {5'd0, 5'd9, 5'd0, 5'd9};
    localparam logic [19:0] P3    = {5'd3, 5'd3, 5'd1, 5'd2};

    logic        step_clk;
    logic        reset;
    logic [3:0]  page_req;
    logic        alert;
    logic        freeze;
    logic [19:0] page0_bcd, page1_bcd, page2_bcd, page3_bcd;
    logic [4:0]  bcd3, bcd2, bcd1, bcd0;
    logic [1:0]  page;
    logic        alert_active;
    logic        page_change;
    logic [19:0] disp;

    int total = 0;
    int bad   = 0;

    assign disp = {bcd3, bcd2, bcd1, bcd0};

    tracker_display_scheduler #(
        .DWELL       (4),
        .ALERT_DWELL (3)
    ) dut (
        .step_clk     (step_clk),
        .reset        (reset),
        .page_req     (page_req),
        .alert        (alert),
        .freeze       (freeze),
        .page0_bcd    (page0_bcd),
        .page1_bcd    (page1_bcd),
        .page2_bcd    (page2_bcd),
        .page3_bcd    (page3_bcd),
        .bcd3         (bcd3),
        .bcd2         (bcd2),
        .bcd1         (bcd1),
        .bcd0         (bcd0),
        .page         (page),
        .alert_active (alert_active),
        .page_change  (page_change)
    );

    initial step_clk = 1'b0;
    always #5 step_clk = ~step_clk;

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // page / alert_active / page_change / digits in one go
    task automatic chk_all(input string tag, input logic [1:0] p, input logic a,
                           input logic pc, input logic [19:0] d);
        chk({tag, ".page"}, 20'(page), 20'(p));
        chk({tag, ".alert_active"}, 20'(alert_active), 20'(a));
        chk({tag, ".page_change"}, 20'(page_change), 20'(pc));
        chk({tag, ".bcd"}, disp, d);
    endtask

    task automatic tick();
        @(negedge step_clk);
    endtask

    initial begin
        reset     = 1'b1;
        page_req  = 4'b0000;
        alert     = 1'b0;
        freeze    = 1'b0;
        page0_bcd = P0;
        page1_bcd = P1;
        page2_bcd = P2;
        page3_bcd = P3;

        // Reset / IDLE
        #1;
        chk_all("reset", 2'd0, 1'b0, 1'b0, BLANK);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("idle_hold", 2'd0, 1'b0, 1'b0, BLANK);
        end

        // Rotation 0 -> 1 -> 3 -> 0
        page_req = 4'b1011;
        tick();
        chk_all("rot_enter_p0", 2'd0, 1'b0, 1'b1, P0);
        tick(); tick(); tick();
        chk_all("rot_p0_last", 2'd0, 1'b0, 1'b0, P0);
        tick();
        chk_all("rot_p1", 2'd1, 1'b0, 1'b1, P1);
        tick(); tick(); tick();
        chk_all("rot_p1_last", 2'd1, 1'b0, 1'b0, P1);
        tick();
        chk_all("rot_p3", 2'd3, 1'b0, 1'b1, P3);
        tick(); tick(); tick(); tick();
        chk_all("rot_wrap_p0", 2'd0, 1'b0, 1'b1, P0);
        page0_bcd = P0B;
        #1;
        chk("data_zero_latency", disp, P0B);
        page0_bcd = P0;

        // Single page, then request drop to IDLE
        page_req = 4'b0100;
        tick();
        chk_all("single_enter_p2", 2'd2, 1'b0, 1'b1, P2);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_all("single_hold_p2", 2'd2, 1'b0, 1'b0, P2);
        end
        page_req = 4'b0000;
        tick();
        chk("drop_idle.pc", 20'(page_change), 20'd1);
        chk("drop_idle.bcd", disp, BLANK);
        tick();
        chk("drop_idle_settle.pc", 20'(page_change), 20'd0);

        // Freeze on p1 at dwell_cnt=2
        page_req = 4'b0110;
        tick();
        chk_all("frz_enter_p1", 2'd1, 1'b0, 1'b1, P1);
        tick(); tick();
        freeze = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all("frz_hold_p1", 2'd1, 1'b0, 1'b0, P1);
        end
        freeze = 1'b0;
        tick();
        chk_all("frz_release_d3", 2'd1, 1'b0, 1'b0, P1);
        tick();
        chk_all("frz_advance_p2", 2'd2, 1'b0, 1'b1, P2);

        // Request drop beats freeze on the same edge
        freeze   = 1'b1;
        page_req = 4'b0010;
        tick();
        chk_all("drop_over_freeze", 2'd1, 1'b0, 1'b1, P1);
        freeze   = 1'b0;
        page_req = 4'b1001;
        tick();
        chk_all("to_p3", 2'd3, 1'b0, 1'b1, P3);

        // Alert from p3, held high
        alert = 1'b1;
        tick();
        chk_all("alert_enter", 2'd0, 1'b1, 1'b1, P0);
        tick();
        chk_all("alert_c1", 2'd0, 1'b1, 1'b0, P0);
        tick();
        chk_all("alert_c2", 2'd0, 1'b1, 1'b0, P0);
        tick();
        chk_all("alert_exit_p0", 2'd0, 1'b0, 1'b1, P0);
        tick();
        chk_all("alert_level_no_retrig1", 2'd0, 1'b0, 1'b0, P0);
        tick();
        chk_all("alert_level_no_retrig2", 2'd0, 1'b0, 1'b0, P0);
        alert = 1'b0;
        tick();
        chk_all("p0_dwell3", 2'd0, 1'b0, 1'b0, P0);
        // Rise coincides with dwell expiry: alert wins
        alert = 1'b1;
        tick();
        chk_all("alert_beats_dwell", 2'd0, 1'b1, 1'b1, P0);
        alert = 1'b0;
        tick();
        chk_all("alert2_c1", 2'd0, 1'b1, 1'b0, P0);
        // Second rise at alert_cnt=1 restarts the window
        alert = 1'b1;
        tick();
        chk_all("alert_retrig", 2'd0, 1'b1, 1'b0, P0);
        tick();
        chk_all("alert_retrig_c1", 2'd0, 1'b1, 1'b0, P0);
        tick();
        chk_all("alert_retrig_c2", 2'd0, 1'b1, 1'b0, P0);
        tick();
        chk_all("alert_retrig_exit", 2'd0, 1'b0, 1'b1, P0);

        // Reset mid-ALERT
        alert = 1'b0;
        tick();
        alert = 1'b1;
        tick();
        chk_all("alert3_enter", 2'd0, 1'b1, 1'b1, P0);
        tick();
        chk_all("alert3_c1", 2'd0, 1'b1, 1'b0, P0);
        reset = 1'b1;
        #1;
        chk_all("reset_mid_alert", 2'd0, 1'b0, 1'b0, BLANK);
        page_req = 4'b0010;
        alert    = 1'b0;
        tick();
        chk_all("reset_held", 2'd0, 1'b0, 1'b0, BLANK);
        reset = 1'b0;
        tick();
        chk_all("post_reset_p1", 2'd1, 1'b0, 1'b1, P1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tracker_display_scheduler.md
# tracker_display_scheduler

Display scheduler for the step tracker's shared four-digit BCD display. It arbitrates the display between four page sources: total steps, distance, seconds over 32 steps/s, and high-activity time. Pages rotate round-robin among the sources currently requesting display, and each page dwells for a fixed number of steps. A milestone alert pre-empts the rotation and forces the step-count page for a fixed window.

## Interface
Parameters:
- DWELL, 16, step_clk edges each page is shown (≥2)
- ALERT_DWELL, 32, step_clk edges the alert page is held (≥2)

Ports:
- step_clk  input  1  clock; all state advances on posedge
- reset  input  1  asynchronous, active-high
- page_req  input  4  per-page display enable; bit n = page n (0 steps, 1 distance, 2 over-32, 3 high activity); synchronous to step_clk
- alert  input  1  milestone level (e.g. si or every-1000-step flag); rising edge triggers alert
- freeze  input  1  hold current page; dwell counter stops
- page0_bcd … page3_bcd  input  20 each  {bcd3,bcd2,bcd1,bcd0}, 5 bits per digit
- bcd3, bcd2, bcd1, bcd0  output  5 each  displayed digits
- page  output  2  index of displayed page
- alert_active  output  1  high while in ALERT
- page_change  output  1  one-cycle pulse after a display change

## Operation
- States: IDLE, SHOW, ALERT. The registers are state, page, dwell_cnt, alert_cnt, alert_q (last-cycle alert) and page_change.
- **Alert edge.** alert_rise = alert & ~alert_q. It has top priority in any state, including under freeze.
  - Enter ALERT with page=0 and alert_cnt=0.
  - A rise while already in ALERT restarts alert_cnt at 0.
- **IDLE.**
  - Outputs show 5'h1F on all digits (blank/underscore).
  - If page_req≠0: go to SHOW on the next edge with page = lowest-index requested bit, dwell_cnt=0.
- **SHOW.** Digits = page_req-selected page data, i.e. pageN_bcd for N=page.
  - If page_req[page]=0: advance immediately on this edge, regardless of freeze or dwell_cnt.
  - Else if freeze=1: hold page and dwell_cnt.
  - Else if dwell_cnt==DWELL-1: advance.
  - Otherwise dwell_cnt+1.
- **Advance.** Search cyclically page+1, page+2, page+3, page for the first set page_req bit.
  - If the found page equals the current page: dwell_cnt restarts at 0 and no page_change.
  - If page_req==0: go to IDLE.
- **ALERT.** Digits = page0_bcd and alert_active=1. freeze and page_req are ignored.
  - When alert_cnt==ALERT_DWELL-1, leave ALERT on that edge:
    - if page_req[0]=1: SHOW page 0, dwell_cnt=0;
    - else advance from page 0 per the rule above (may go to IDLE).
  - Otherwise alert_cnt+1.
- **Counter widths.** dwell_cnt is $clog2(DWELL) bits and alert_cnt is $clog2(ALERT_DWELL) bits. Neither wraps past its terminal value.
- **page_change.** Registered. It is high for exactly the one cycle following an edge on which any of the following changed:
  - the page value;
  - alert_active;
  - the IDLE/non-IDLE status.
- **Reset mid-operation.** Immediately returns all registers to their reset values. Digits blank asynchronously.

## Timing
- **Reset values:**
  - state=IDLE, page=0, dwell_cnt=0, alert_cnt=0, alert_q=0;
  - alert_active=0, page_change=0;
  - bcd3..bcd0=5'h1F.
- page, alert_active and page_change are registered.
- bcd outputs are a combinational mux of the page data, selected by the registered state/page. Data changes on pageN_bcd propagate with zero latency.
- Dwell: a page whose request stays set, with freeze low, is displayed for exactly DWELL step_clk edges.
- Alert: alert_active goes high one edge after alert rises and stays high for exactly ALERT_DWELL edges.
- alert_rise and a dwell expiry on the same edge: ALERT wins.
- The page_req drop rule and freeze on the same edge: the drop wins (advance).
- A level alert held high does not retrigger; only a new rising edge does.

## Test plan
Run all scenarios with DWELL=4 and ALERT_DWELL=3.
- **Reset/IDLE:** assert reset with page_req=0 -> bcd=1F/1F/1F/1F, page=0, alert_active=0, page_change=0. Hold for 10 edges -> no change.
- **Rotation:** page_req=4'b1011 -> SHOW p0 for 4 edges, then p1 for 4, then p3 for 4, then p0. page_change pulses once per switch. Digits track page data.
- **Single page / request drop:** page_req=4'b0100 -> p2 held indefinitely, no page_change after entry. Clear bit 2 mid-dwell -> IDLE on the next edge, blank digits, one page_change.
- **Freeze:** on p1 at dwell_cnt=2, freeze=1 for 6 edges -> page stays 1. Release -> advance after 1 more edge.
- **Alert:** alert rise while on p3 -> page=0, alert_active=1 for 3 edges, then return to p0 (page_req[0]=1). Second rise at alert_cnt=1 -> ALERT extended to 3 edges from the new rise. Alert held high -> no retrigger.
- **Reset mid-ALERT:** assert reset at alert_cnt=1 -> immediate blank digits, alert_active=0. After release with page_req=4'b0010 -> p1 on the first edge.
